vend_ctrl_param: RTL and testbench
==================================

VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 SHALL have parameter SEL_W, default 3, product-select width; N_PROD = 2**SEL_W products.
REQ-002 SHALL have parameter INV_W, default 4, per-product inventory width; INV_MAX = 2**INV_W-1.
REQ-003 SHALL have parameter BAL_W, default 8, width of balance and prices.
REQ-004 SHALL have parameter BAL_MAX, default 200, credit ceiling in cents; BAL_MAX < 2**BAL_W.
REQ-005 SHALL have parameter TIMEOUT, default 1000, idle cycles in CREDIT before auto-refund.
REQ-006 SHALL have parameter PRICE_INIT, N_PROD*BAL_W bits, reset price of product i in slice [i*BAL_W +: BAL_W]; default {100,90,75,50,40,25,10,10} (product 7 first).
REQ-007 SHALL have parameter INV_INIT, N_PROD*INV_W bits, reset inventory; default {2,5,3,4,1,2,2,3} (product 7 first).
REQ-008 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-009 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-010 SHALL have ports coin_valid in 1, coin_type in 2: coin strobe; 00=5, 01=10, 10=25, 11=100 cents.
REQ-011 SHALL have ports sel_valid in 1, sel in SEL_W: purchase request.
REQ-012 SHALL have port cancel  in  1  request refund of current credit.
REQ-013 SHALL have ports cfg_we in 1, cfg_op in 1 (0=set price, 1=add inventory), cfg_sel in SEL_W, cfg_data in BAL_W.
REQ-014 SHALL have ports vend_valid out 1, vend_id out SEL_W, vend_ready in 1: product dispense handshake.
REQ-015 SHALL have ports chg_valid out 1, chg_type out 2 (coin_type encoding, 00..10 only), chg_ready in 1: change-coin handshake.
REQ-016 SHALL have ports balance out BAL_W, state out 2 (0 IDLE, 1 CREDIT, 2 VEND, 3 CHANGE), status out 3.
REQ-017 SHALL have ports qry_sel in SEL_W, qry_price out BAL_W, qry_inv out INV_W: registered lookup.

Function
REQ-018 SHALL transfer on valid&ready at a rising edge; vend_id/chg_type SHALL hold stable while valid is high and unaccepted.
REQ-019 SHALL, in IDLE or CREDIT on coin_valid, add the coin value if balance+value <= BAL_MAX and enter CREDIT; else reject (balance unchanged, status=1).
REQ-020 SHALL reject coins in VEND and CHANGE (status=1, balance unchanged).
REQ-021 SHALL, in CREDIT on sel_valid: inventory 0 -> status=2, stay; balance < price -> status=3, stay; else balance -= price, inventory -= 1, status=0, enter VEND.
REQ-022 SHALL assert vend_valid with vend_id=sel from the cycle after entering VEND until accepted; on acceptance go CHANGE if balance >= 5, else clear balance and go IDLE.
REQ-023 SHALL in CHANGE emit greedy coins: 25 if balance >= 25, else 10 if >= 10, else 5; subtract on acceptance; when balance < 5 clear the remainder (forfeit) and go IDLE.
REQ-024 SHALL in CREDIT apply priority cancel > sel_valid > coin_valid; a coin coincident with cancel or sel_valid is rejected (status=1 unless sel sets 2/3/0).
REQ-025 SHALL on cancel in CREDIT go CHANGE; cancel in IDLE, VEND or CHANGE is ignored.
REQ-026 SHALL count cycles in CREDIT with none of coin_valid, sel_valid, cancel; at count == TIMEOUT go CHANGE with status=4; any such input resets the count.
REQ-027 SHALL apply cfg_we only in IDLE: op 0 sets price to min(cfg_data, BAL_MAX); op 1 adds cfg_data to inventory saturating at INV_MAX; cfg_we outside IDLE ignored with status=5.
REQ-028 SHALL drive qry_price/qry_inv one cycle after qry_sel, reflecting state after that edge's updates.
REQ-029 SHALL register balance, state and status; status holds last event code until next event.
REQ-030 SHALL never wrap balance or inventory arithmetic.

Reset
REQ-031 SHALL, when reset_n=0 at an edge: state IDLE, balance 0, status 0, vend_valid 0, chg_valid 0, timeout count 0, prices=PRICE_INIT, inventory=INV_INIT, qry outputs 0; reset mid-transaction discards pending vend/change.

Verification
REQ-032 Coins 25,25,10 then sel=2 -> balance 60->35, vend_id=2 handshake, change 25,10, IDLE, inv[2]=1.
REQ-033 Balance 190 + coin 25 -> rejected, status=1, balance 190; + coin 10 -> 200.
REQ-034 sel=3 twice with balance 100 -> first vends (inv 1->0), second status=2, balance 60 held.
REQ-035 Coin 5, no activity TIMEOUT cycles -> CHANGE, status=4, single 5-cent coin out; chg_ready held low 10 cycles -> chg_valid/chg_type stable.
REQ-036 cfg op1 add 15 to product 0 (inv 3) -> 15; cfg op0 price 250 -> 200; cfg_we in CREDIT -> status=5, no change.
REQ-037 Reset asserted during CHANGE with balance 35 -> next cycle IDLE, balance 0, chg_valid 0, prices/inventory at init.

Source files
------------

// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// vend_ctrl_param : parameterised coin vending controller with greedy change
// rev 1.0
// ============================================================================
module vend_ctrl_param #(
    parameter int SEL_W   = 3,
    parameter int INV_W   = 4,
    parameter int BAL_W   = 8,
    parameter int BAL_MAX = 200,
    parameter int TIMEOUT = 1000,
    parameter logic [(2**SEL_W)*BAL_W-1:0] PRICE_INIT =
        {8'd100, 8'd90, 8'd75, 8'd50, 8'd40, 8'd25, 8'd10, 8'd10},
    parameter logic [(2**SEL_W)*INV_W-1:0] INV_INIT =
        {4'd2, 4'd5, 4'd3, 4'd4, 4'd1, 4'd2, 4'd2, 4'd3}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             cancel,
    input  logic             cfg_we,
    input  logic             cfg_op,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [BAL_W-1:0] cfg_data,
    output logic             vend_valid,
    output logic [SEL_W-1:0] vend_id,
    input  logic             vend_ready,
    output logic             chg_valid,
    output logic [1:0]       chg_type,
    input  logic             chg_ready,
    output logic [BAL_W-1:0] balance,
    output logic [1:0]       state,
    output logic [2:0]       status,
    input  logic [SEL_W-1:0] qry_sel,
    output logic [BAL_W-1:0] qry_price,
    output logic [INV_W-1:0] qry_inv
);

    localparam int N_PROD  = 2**SEL_W;
    localparam int INV_MAX = 2**INV_W - 1;
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int SW      = BAL_W + 8;
    localparam int AW      = BAL_W + INV_W + 1;
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    function automatic logic [SW-1:0] coin_value(input logic [1:0] t);
        case (t)
            2'b00:   coin_value = SW'(5);
            2'b01:   coin_value = SW'(10);
            2'b10:   coin_value = SW'(25);
            default: coin_value = SW'(100);
        endcase
    endfunction

    function automatic logic [1:0] change_code(input logic [BAL_W-1:0] b);
        if (b >= BAL_W'(25))      change_code = 2'b10;
        else if (b >= BAL_W'(10)) change_code = 2'b01;
        else                      change_code = 2'b00;
    endfunction

    function automatic logic [BAL_W-1:0] change_amount(input logic [1:0] c);
        case (c)
            2'b10:   change_amount = BAL_W'(25);
            2'b01:   change_amount = BAL_W'(10);
            default: change_amount = BAL_W'(5);
        endcase
    endfunction

    state_t           r_state;
    logic [TW-1:0]    r_tcount;
    logic [BAL_W-1:0] r_price     [N_PROD];
    logic [INV_W-1:0] r_inv       [N_PROD];
    logic [BAL_W-1:0] w_price_nxt [N_PROD];
    logic [INV_W-1:0] w_inv_nxt   [N_PROD];

    logic [SW-1:0]    w_coin_sum;
    logic             w_coin_fits;
    logic [BAL_W-1:0] w_sel_price;
    logic [INV_W-1:0] w_sel_inv;
    logic             w_sel_ok;
    logic [TW-1:0]    w_tnext;
    logic             w_refund;
    logic             w_bal_ge5;
    logic [1:0]       w_chg_code;
    logic [BAL_W-1:0] w_chg_left;
    logic [BAL_W-1:0] w_cfg_price;
    logic [AW-1:0]    w_inv_sum;
    logic [INV_W-1:0] w_inv_add;

    assign state       = r_state;
    assign w_coin_sum  = SW'(balance) + coin_value(coin_type);
    assign w_coin_fits = (w_coin_sum <= SW'(BAL_MAX));
    assign w_sel_price = r_price[sel];
    assign w_sel_inv   = r_inv[sel];
    assign w_sel_ok    = (r_state == S_CREDIT) && !cancel && sel_valid &&
                         (w_sel_inv != '0) && (balance >= w_sel_price);
    assign w_tnext     = r_tcount + TW'(1);
    // Refund on cancel, or when this idle cycle completes the timeout window
    assign w_refund    = cancel || (!sel_valid && !coin_valid && (w_tnext == c_timeout));
    assign w_bal_ge5   = (balance >= BAL_W'(5));
    assign w_chg_code  = change_code(balance);
    assign w_chg_left  = balance - change_amount(chg_type);
    assign w_cfg_price = (cfg_data > BAL_W'(BAL_MAX)) ? BAL_W'(BAL_MAX) : cfg_data;
    assign w_inv_sum   = AW'(r_inv[cfg_sel]) + AW'(cfg_data);
    assign w_inv_add   = (w_inv_sum > AW'(INV_MAX)) ? INV_W'(INV_MAX) : w_inv_sum[INV_W-1:0];

    // Vends happen only in CREDIT and config only in IDLE, so the updates never collide
    always_comb begin
        for (int i = 0; i < N_PROD; i++) begin
            w_price_nxt[i] = r_price[i];
            w_inv_nxt[i]   = r_inv[i];
        end
        if (w_sel_ok)
            w_inv_nxt[sel] = r_inv[sel] - INV_W'(1);
        if (cfg_we && (r_state == S_IDLE)) begin
            if (!cfg_op) w_price_nxt[cfg_sel] = w_cfg_price;
            else         w_inv_nxt[cfg_sel]   = w_inv_add;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PROD; i++) begin
                r_price[i] <= PRICE_INIT[i*BAL_W +: BAL_W];
                r_inv[i]   <= INV_INIT[i*INV_W +: INV_W];
            end
            qry_price <= '0;
            qry_inv   <= '0;
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                r_price[i] <= w_price_nxt[i];
                r_inv[i]   <= w_inv_nxt[i];
            end
            qry_price <= w_price_nxt[qry_sel];
            qry_inv   <= w_inv_nxt[qry_sel];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tcount   <= '0;
            balance    <= '0;
            status     <= '0;
            vend_valid <= 1'b0;
            vend_id    <= '0;
            chg_valid  <= 1'b0;
            chg_type   <= '0;
        end else begin
            // Any event code written below takes precedence over a misplaced config write
            if (cfg_we && (r_state != S_IDLE))
                status <= 3'd5;
            case (r_state)
                S_IDLE: begin
                    if (coin_valid) begin
                        if (w_coin_fits) begin
                            balance  <= w_coin_sum[BAL_W-1:0];
                            r_state  <= S_CREDIT;
                            r_tcount <= '0;
                        end else begin
                            status <= 3'd1;
                        end
                    end
                end
                S_CREDIT: begin
                    if (w_refund) begin
                        r_tcount <= '0;
                        if (!cancel)         status <= 3'd4;
                        else if (coin_valid) status <= 3'd1;
                        if (w_bal_ge5) begin
                            r_state   <= S_CHANGE;
                            chg_valid <= 1'b1;
                            chg_type  <= w_chg_code;
                        end else begin
                            balance <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (sel_valid) begin
                        r_tcount <= '0;
                        if (w_sel_inv == '0) begin
                            status <= 3'd2;
                        end else if (!w_sel_ok) begin
                            status <= 3'd3;
                        end else begin
                            status     <= 3'd0;
                            balance    <= balance - w_sel_price;
                            r_state    <= S_VEND;
                            vend_valid <= 1'b1;
                            vend_id    <= sel;
                        end
                    end else if (coin_valid) begin
                        r_tcount <= '0;
                        if (w_coin_fits) balance <= w_coin_sum[BAL_W-1:0];
                        else             status  <= 3'd1;
                    end else begin
                        r_tcount <= w_tnext;
                    end
                end
                S_VEND: begin
                    if (coin_valid) status <= 3'd1;
                    if (vend_valid && vend_ready) begin
                        vend_valid <= 1'b0;
                        if (w_bal_ge5) begin
                            r_state   <= S_CHANGE;
                            chg_valid <= 1'b1;
                            chg_type  <= w_chg_code;
                        end else begin
                            balance <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    if (coin_valid) status <= 3'd1;
                    if (chg_valid && chg_ready) begin
                        if (w_chg_left >= BAL_W'(5)) begin
                            balance  <= w_chg_left;
                            chg_type <= change_code(w_chg_left);
                        end else begin
                            balance   <= '0;
                            chg_valid <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// tb_vend_ctrl_param : directed scenarios plus random traffic against a model
// rev 1.0
// ============================================================================
module tb_vend_ctrl_param;

    localparam int SEL_W   = 3;
    localparam int INV_W   = 4;
    localparam int BAL_W   = 8;
    localparam int BAL_MAX = 200;
    localparam int TIMEOUT = 24;
    localparam int NP      = 8;

    logic             clock = 1'b0;
    logic             reset_n, coin_valid, sel_valid, cancel, cfg_we, cfg_op;
    logic [1:0]       coin_type;
    logic [SEL_W-1:0] sel, cfg_sel, qry_sel;
    logic [BAL_W-1:0] cfg_data;
    logic             vend_ready, chg_ready;
    logic             vend_valid, chg_valid;
    logic [SEL_W-1:0] vend_id;
    logic [1:0]       chg_type, state;
    logic [BAL_W-1:0] balance, qry_price;
    logic [2:0]       status;
    logic [INV_W-1:0] qry_inv;

    always #5 clock = ~clock;

    vend_ctrl_param #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .vend_valid(vend_valid), .vend_id(vend_id), .vend_ready(vend_ready),
        .chg_valid(chg_valid), .chg_type(chg_type), .chg_ready(chg_ready),
        .balance(balance), .state(state), .status(status),
        .qry_sel(qry_sel), .qry_price(qry_price), .qry_inv(qry_inv)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: integer bookkeeping, refunds as a precomputed coin queue
    int m_price[NP], m_inv[NP];
    int m_bal, m_st, m_status, m_tcnt, m_vid, m_qp, m_qi;
    bit m_vv;
    int m_q[$];
    int init_price[NP] = '{10, 10, 25, 40, 50, 75, 90, 100};
    int init_inv[NP]   = '{3, 2, 2, 1, 4, 3, 5, 2};

    function automatic int cval(logic [1:0] t);
        return (t == 2'd0) ? 5 : (t == 2'd1) ? 10 : (t == 2'd2) ? 25 : 100;
    endfunction

    function automatic int ccode(int v);
        return (v == 25) ? 2 : (v == 10) ? 1 : 0;
    endfunction

    function automatic void m_refund();
        int b, c;
        b = m_bal;
        m_q.delete();
        while (b >= 5) begin
            c = (b >= 25) ? 25 : (b >= 10) ? 10 : 5;
            m_q.push_back(c);
            b -= c;
        end
        if (m_q.size() == 0) begin
            m_bal = 0;
            m_st  = 0;
        end else begin
            m_st = 3;
        end
    endfunction

    always @(posedge clock) begin : p_model
        int cv;
        if (!reset_n) begin
            for (int i = 0; i < NP; i++) begin
                m_price[i] = init_price[i];
                m_inv[i]   = init_inv[i];
            end
            m_bal = 0; m_st = 0; m_status = 0; m_tcnt = 0; m_vid = 0;
            m_vv = 1'b0; m_q.delete(); m_qp = 0; m_qi = 0;
        end else begin
            cv = cval(coin_type);
            if (cfg_we && m_st != 0) m_status = 5;
            case (m_st)
                0: begin
                    if (cfg_we) begin
                        if (!cfg_op) m_price[cfg_sel] = (cfg_data > BAL_MAX) ? BAL_MAX : int'(cfg_data);
                        else         m_inv[cfg_sel] = (m_inv[cfg_sel] + cfg_data > 15) ? 15 : m_inv[cfg_sel] + int'(cfg_data);
                    end
                    if (coin_valid) begin
                        if (m_bal + cv <= BAL_MAX) begin
                            m_bal += cv; m_st = 1; m_tcnt = 0;
                        end else m_status = 1;
                    end
                end
                1: begin
                    if (cancel) begin
                        if (coin_valid) m_status = 1;
                        m_tcnt = 0;
                        m_refund();
                    end else if (sel_valid) begin
                        m_tcnt = 0;
                        if (m_inv[sel] == 0)            m_status = 2;
                        else if (m_bal < m_price[sel])  m_status = 3;
                        else begin
                            m_status = 0;
                            m_bal -= m_price[sel];
                            m_inv[sel] -= 1;
                            m_vv = 1'b1; m_vid = sel; m_st = 2;
                        end
                    end else if (coin_valid) begin
                        m_tcnt = 0;
                        if (m_bal + cv <= BAL_MAX) m_bal += cv;
                        else                       m_status = 1;
                    end else begin
                        m_tcnt++;
                        if (m_tcnt == TIMEOUT) begin
                            m_tcnt = 0; m_status = 4;
                            m_refund();
                        end
                    end
                end
                2: begin
                    if (coin_valid) m_status = 1;
                    if (vend_ready) begin
                        m_vv = 1'b0;
                        if (m_bal >= 5) m_refund();
                        else begin m_bal = 0; m_st = 0; end
                    end
                end
                default: begin
                    if (coin_valid) m_status = 1;
                    if (chg_ready) begin
                        m_bal -= m_q.pop_front();
                        if (m_q.size() == 0) begin m_bal = 0; m_st = 0; end
                    end
                end
            endcase
            m_qp = m_price[qry_sel];
            m_qi = m_inv[qry_sel];
        end
    end

    always @(negedge clock) begin : p_compare
        if (chk_en) begin
            chk("state", state, m_st);
            chk("balance", balance, m_bal);
            chk("status", status, m_status);
            chk("vend_valid", vend_valid, m_vv);
            if (m_vv) chk("vend_id", vend_id, m_vid);
            chk("chg_valid", chg_valid, (m_st == 3));
            if (m_st == 3 && m_q.size() > 0) chk("chg_type", chg_type, ccode(m_q[0]));
            chk("qry_price", qry_price, m_qp);
            chk("qry_inv", qry_inv, m_qi);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        vend_ready = 1'b1; chg_ready = 1'b1;
        if (m_st == 1) begin cancel = 1'b1; step(); cancel = 1'b0; end
        n = 0;
        while (m_st != 0 && n < 60) begin step(); n++; end
        chk("drain_idle", state, 0);
        vend_ready = 1'b0; chg_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0;
        sel = '0; cancel = 1'b0; cfg_we = 1'b0; cfg_op = 1'b0; cfg_sel = '0;
        cfg_data = '0; vend_ready = 1'b0; chg_ready = 1'b0; qry_sel = '0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_state", state, 0);
        chk("rst_balance", balance, 0);
        chk("rst_status", status, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_qry_price", qry_price, 0);
        reset_n = 1'b1; qry_sel = 3'd2;
        step();
        chk("init_price2", qry_price, 25);
        chk("init_inv2", qry_inv, 2);

        // purchase with change
        coin(2'd2); coin(2'd2); coin(2'd1);
        chk("buy_bal60", balance, 60);
        sel_valid = 1'b1; sel = 3'd2; step(); sel_valid = 1'b0;
        chk("buy_bal35", balance, 35);
        chk("buy_vend_id", vend_id, 2);
        chk("buy_state_vend", state, 2);
        step();
        chk("buy_vend_hold", vend_valid, 1);
        vend_ready = 1'b1; step(); vend_ready = 1'b0;
        chk("buy_chg25", chg_type, 2);
        chg_ready = 1'b1; step();
        chk("buy_chg10", chg_type, 1);
        chk("buy_bal10", balance, 10);
        step(); chg_ready = 1'b0;
        chk("buy_idle", state, 0);
        chk("buy_model_inv2", m_inv[2], 1);
        step();
        chk("buy_inv2", qry_inv, 1);

        // credit ceiling
        coin(2'd3); coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd1); coin(2'd0);
        chk("ceil_bal190", balance, 190);
        coin(2'd2);
        chk("ceil_reject_bal", balance, 190);
        chk("ceil_reject_status", status, 1);
        coin(2'd1);
        chk("ceil_bal200", balance, 200);
        drain();

        // sold-out and insufficient-funds
        qry_sel = 3'd3;
        coin(2'd3);
        sel_valid = 1'b1; sel = 3'd3; step(); sel_valid = 1'b0;
        chk("so_bal60", balance, 60);
        drain();
        chk("so_inv3", qry_inv, 0);
        coin(2'd2); coin(2'd2); coin(2'd1);
        sel_valid = 1'b1; sel = 3'd3; step(); sel_valid = 1'b0;
        chk("so_status2", status, 2);
        chk("so_bal_held", balance, 60);
        chk("so_state_credit", state, 1);
        sel_valid = 1'b1; sel = 3'd7; step(); sel_valid = 1'b0;
        chk("poor_status3", status, 3);
        drain();

        // inactivity refund with stalled change handshake
        coin(2'd0);
        repeat (TIMEOUT - 1) step();
        chk("to_not_yet", state, 1);
        step();
        chk("to_state_change", state, 3);
        chk("to_status4", status, 4);
        repeat (10) step();
        chk("to_chg_valid_held", chg_valid, 1);
        chk("to_chg_type_held", chg_type, 0);
        chk("to_bal_held", balance, 5);
        chg_ready = 1'b1; step(); chg_ready = 1'b0;
        chk("to_idle", state, 0);
        chk("to_chg_done", chg_valid, 0);

        // configuration
        qry_sel = 3'd0;
        cfg_we = 1'b1; cfg_op = 1'b1; cfg_sel = 3'd0; cfg_data = 8'd15; step();
        chk("cfg_inv_sat", qry_inv, 15);
        cfg_op = 1'b0; cfg_data = 8'd250; step(); cfg_we = 1'b0;
        chk("cfg_price_clamp", qry_price, 200);
        coin(2'd1);
        cfg_we = 1'b1; cfg_op = 1'b0; cfg_data = 8'd50; step(); cfg_we = 1'b0;
        chk("cfg_busy_status", status, 5);
        chk("cfg_busy_price", qry_price, 200);
        drain();

        // reset in the middle of a refund
        coin(2'd2); coin(2'd1);
        cancel = 1'b1; step(); cancel = 1'b0;
        chk("mid_state_change", state, 3);
        chk("mid_bal35", balance, 35);
        reset_n = 1'b0; step(); reset_n = 1'b1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_bal", balance, 0);
        chk("mid_rst_chg", chg_valid, 0);
        step();
        chk("mid_rst_price0", qry_price, 10);
        chk("mid_rst_inv0", qry_inv, 3);

        // random traffic
        begin
            int quiet = 0;
            for (int i = 0; i < 4000; i++) begin
                reset_n    = ($urandom_range(0, 199) != 0);
                coin_valid = ($urandom_range(0, 99) < 25);
                coin_type  = 2'($urandom_range(0, 3));
                sel_valid  = ($urandom_range(0, 99) < 12);
                sel        = 3'($urandom_range(0, 7));
                cancel     = ($urandom_range(0, 99) < 3);
                cfg_we     = ($urandom_range(0, 99) < 6);
                cfg_op     = 1'($urandom_range(0, 1));
                cfg_sel    = 3'($urandom_range(0, 7));
                cfg_data   = ($urandom_range(0, 99) < 80) ? 8'($urandom_range(0, 60))
                                                          : 8'($urandom_range(0, 255));
                vend_ready = ($urandom_range(0, 99) < 50);
                chg_ready  = ($urandom_range(0, 99) < 50);
                qry_sel    = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 149) == 0) quiet = TIMEOUT + 6;
                if (quiet > 0) begin
                    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
                    quiet--;
                end
                step();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
